neighbor_builder: RTL and testbench

NEIGHBOR_BUILDER -- requirements
Module: neighbor_builder

---
 rtl/neighbor_builder.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_neighbor_builder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neighbor_builder.sv
// neighbor_builder: walks the face list of a triangle mesh held in the object
// RAM and builds a fixed-size neighbor slot per vertex in the neighbor RAM.
// Optional feature macro NBR_DEDUP_EN: when defined, each directed edge first
// scans the existing list and skips neighbors already present; when undefined
// every directed edge is appended (duplicates stored).
// RAM address width comes from the ADDR_WIDTH define (default 11).
// State advances on the falling clock edge so that the RAMs, which sample on
// the rising edge, see stable address/data and return read data in time for
// the following falling edge.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 11
`endif

module neighbor_builder #(
  parameter int MAX_NEIGHBOR_COUNT = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [31:0]            vertex_count,
  input  logic [31:0]            face_count,
  input  logic [31:0]            RAM_OBJ_Do,
  output logic                   RAM_OBJ_EN,
  output logic [3:0]             RAM_OBJ_WE,
  output logic [`ADDR_WIDTH-1:0] RAM_OBJ_A,
  output logic [31:0]            RAM_OBJ_Di,
  input  logic [31:0]            RAM_NBR_Do,
  output logic                   RAM_NBR_EN,
  output logic [3:0]             RAM_NBR_WE,
  output logic [`ADDR_WIDTH-1:0] RAM_NBR_A,
  output logic [31:0]            RAM_NBR_Di,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int AW = `ADDR_WIDTH;
  // A slot holds one count word, so at most MAX_NEIGHBOR_COUNT-1 neighbors.
  localparam logic [31:0] SLOT_CAP = 32'(MAX_NEIGHBOR_COUNT - 1);

`ifdef NBR_DEDUP_EN
  typedef enum logic [2:0] {
    IDLE, CLEAR, FETCH_FACE, READ_COUNT, SCAN, APPEND, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, CLEAR, FETCH_FACE, READ_COUNT, APPEND, DONE
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [31:0]     vtx_q, vtx_d;       // next vertex to clear (0-based)
  logic [31:0]     face_q, face_d;     // current face (0-based)
  logic [1:0]      phase_q, phase_d;   // sub-step inside FETCH_FACE / APPEND
  logic [2:0]      edge_q, edge_d;     // directed edge 0..5 of current face
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     c_q, c_d;
  logic [31:0]     cnt_q, cnt_d;       // neighbor count of the edge source
`ifdef NBR_DEDUP_EN
  logic [31:0]     scan_q, scan_d;     // list position being compared (1-based)
`endif
  logic            en_q, en_d;
  logic [AW-1:0]   obj_a_q, obj_a_d;
  logic [AW-1:0]   nbr_a_q, nbr_a_d;
  logic [31:0]     nbr_di_q, nbr_di_d;
  logic [3:0]      nbr_we_q, nbr_we_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;

  logic [31:0]     src, dst, nxt_src, cnt_sel;
  logic            do_decide, do_adv;

  // Word address of the count word of 1-based vertex v.
  function automatic logic [AW-1:0] slot_base(input logic [AW-1:0] v);
    logic [AW-1:0] vm1;
    vm1 = v - AW'(1);
    return vm1 * AW'(MAX_NEIGHBOR_COUNT);
  endfunction

  // Word address of corner k of face f; faces follow the vertex block.
  function automatic logic [AW-1:0] corner_addr(input logic [AW-1:0] vc,
                                                input logic [AW-1:0] f,
                                                input logic [1:0]    k);
    return vc * AW'(3) + AW'(1) + f * AW'(3) + AW'(k);
  endfunction

  // Source/destination of the current directed edge: ab, ba, bc, cb, ca, ac.
  always_comb begin
    src = a_q;
    dst = b_q;
    case (edge_q)
      3'd0:    begin src = a_q; dst = b_q; end
      3'd1:    begin src = b_q; dst = a_q; end
      3'd2:    begin src = b_q; dst = c_q; end
      3'd3:    begin src = c_q; dst = b_q; end
      3'd4:    begin src = c_q; dst = a_q; end
      default: begin src = a_q; dst = c_q; end
    endcase
  end

  // Source of the following edge, used to prefetch its count word.
  always_comb begin
    nxt_src = a_q;
    case (edge_q)
      3'd0:    nxt_src = b_q;
      3'd1:    nxt_src = b_q;
      3'd2:    nxt_src = c_q;
      3'd3:    nxt_src = c_q;
      default: nxt_src = a_q;
    endcase
  end

  // Next-state and next-output logic for the build sequencer.
  always_comb begin
    state_d   = state_q;
    vtx_d     = vtx_q;
    face_d    = face_q;
    phase_d   = phase_q;
    edge_d    = edge_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
`ifdef NBR_DEDUP_EN
    scan_d    = scan_q;
`endif
    en_d      = en_q;
    obj_a_d   = obj_a_q;
    nbr_a_d   = nbr_a_q;
    nbr_di_d  = nbr_di_q;
    nbr_we_d  = 4'b0000;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    do_decide = 1'b0;
    do_adv    = 1'b0;
    cnt_sel   = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          busy_d  = 1'b1;
          en_d    = 1'b1;
          ovf_d   = 1'b0;
          vtx_d   = 32'd0;
        end
      end

      CLEAR: begin
        if (vtx_q < vertex_count) begin
          nbr_a_d  = slot_base(vtx_q[AW-1:0] + AW'(1));
          nbr_di_d = 32'd0;
          nbr_we_d = 4'b1111;
          vtx_d    = vtx_q + 32'd1;
        end else if (face_count == 32'd0) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          en_d    = 1'b0;
        end else begin
          state_d = FETCH_FACE;
          face_d  = 32'd0;
          phase_d = 2'd0;
          obj_a_d = corner_addr(vertex_count[AW-1:0], '0, 2'd0);
        end
      end

      FETCH_FACE: begin
        case (phase_q)
          2'd0: begin
            a_d     = RAM_OBJ_Do;
            obj_a_d = corner_addr(vertex_count[AW-1:0], face_q[AW-1:0], 2'd1);
            phase_d = 2'd1;
          end
          2'd1: begin
            b_d     = RAM_OBJ_Do;
            obj_a_d = corner_addr(vertex_count[AW-1:0], face_q[AW-1:0], 2'd2);
            phase_d = 2'd2;
          end
          default: begin
            c_d     = RAM_OBJ_Do;
            state_d = READ_COUNT;
            edge_d  = 3'd0;
            nbr_a_d = slot_base(a_q[AW-1:0]);
          end
        endcase
      end

      READ_COUNT: begin
        cnt_d = RAM_NBR_Do;
`ifdef NBR_DEDUP_EN
        if (RAM_NBR_Do == 32'd0) begin
          cnt_sel   = RAM_NBR_Do;
          do_decide = 1'b1;
        end else begin
          state_d = SCAN;
          scan_d  = 32'd1;
          nbr_a_d = slot_base(src[AW-1:0]) + AW'(1);
        end
`else
        cnt_sel   = RAM_NBR_Do;
        do_decide = 1'b1;
`endif
      end

`ifdef NBR_DEDUP_EN
      SCAN: begin
        if (RAM_NBR_Do == dst) begin
          do_adv = 1'b1;
        end else if (scan_q >= cnt_q) begin
          do_decide = 1'b1;
        end else begin
          scan_d  = scan_q + 32'd1;
          nbr_a_d = slot_base(src[AW-1:0]) + scan_q[AW-1:0] + AW'(1);
        end
      end
`endif

      APPEND: begin
        // Phase 0 shows the neighbor write; queue the count update behind it.
        if (phase_q == 2'd0) begin
          nbr_a_d  = slot_base(src[AW-1:0]);
          nbr_di_d = cnt_q + 32'd1;
          nbr_we_d = 4'b1111;
          phase_d  = 2'd1;
        end else begin
          do_adv = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // No match found: append if the slot has room, otherwise flag overflow.
    if (do_decide) begin
      if (cnt_sel < SLOT_CAP) begin
        state_d  = APPEND;
        phase_d  = 2'd0;
        nbr_a_d  = slot_base(src[AW-1:0]) + cnt_sel[AW-1:0] + AW'(1);
        nbr_di_d = dst;
        nbr_we_d = 4'b1111;
      end else begin
        ovf_d  = 1'b1;
        do_adv = 1'b1;
      end
    end

    // Move on to the next edge, the next face, or finish.
    if (do_adv) begin
      if (edge_q == 3'd5) begin
        if (face_q + 32'd1 >= face_count) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          en_d    = 1'b0;
        end else begin
          state_d = FETCH_FACE;
          face_d  = face_q + 32'd1;
          phase_d = 2'd0;
          obj_a_d = corner_addr(vertex_count[AW-1:0], face_q[AW-1:0] + AW'(1), 2'd0);
        end
      end else begin
        state_d = READ_COUNT;
        edge_d  = edge_q + 3'd1;
        nbr_a_d = slot_base(nxt_src[AW-1:0]);
      end
    end
  end

  // State and registered outputs, falling-edge clocked, async active-low reset.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vtx_q    <= '0;
      face_q   <= '0;
      phase_q  <= '0;
      edge_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
`ifdef NBR_DEDUP_EN
      scan_q   <= '0;
`endif
      en_q     <= 1'b0;
      obj_a_q  <= '0;
      nbr_a_q  <= '0;
      nbr_di_q <= '0;
      nbr_we_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vtx_q    <= vtx_d;
      face_q   <= face_d;
      phase_q  <= phase_d;
      edge_q   <= edge_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
`ifdef NBR_DEDUP_EN
      scan_q   <= scan_d;
`endif
      en_q     <= en_d;
      obj_a_q  <= obj_a_d;
      nbr_a_q  <= nbr_a_d;
      nbr_di_q <= nbr_di_d;
      nbr_we_q <= nbr_we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  // The object RAM is only ever read.
  assign RAM_OBJ_EN = en_q;
  assign RAM_OBJ_WE = 4'b0000;
  assign RAM_OBJ_A  = obj_a_q;
  assign RAM_OBJ_Di = 32'd0;
  assign RAM_NBR_EN = en_q;
  assign RAM_NBR_WE = nbr_we_q;
  assign RAM_NBR_A  = nbr_a_q;
  assign RAM_NBR_Di = nbr_di_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_neighbor_builder.sv
// Testbench for neighbor_builder: RAM models, a list-based reference model of
// the neighbor slots, and one task per scenario.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 11
`endif

module tb_neighbor_builder;

  localparam int AW    = `ADDR_WIDTH;
  localparam int MAXN  = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [31:0]   vertex_count, face_count;
  logic [31:0]   RAM_OBJ_Do, RAM_NBR_Do;
  logic          RAM_OBJ_EN, RAM_NBR_EN;
  logic [3:0]    RAM_OBJ_WE, RAM_NBR_WE;
  logic [AW-1:0] RAM_OBJ_A, RAM_NBR_A;
  logic [31:0]   RAM_OBJ_Di, RAM_NBR_Di;
  logic          busy, done, overflow;

  int n_err = 0;
  int n_checks = 0;

  neighbor_builder #(.MAX_NEIGHBOR_COUNT(MAXN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .vertex_count(vertex_count), .face_count(face_count),
    .RAM_OBJ_Do(RAM_OBJ_Do), .RAM_OBJ_EN(RAM_OBJ_EN), .RAM_OBJ_WE(RAM_OBJ_WE),
    .RAM_OBJ_A(RAM_OBJ_A), .RAM_OBJ_Di(RAM_OBJ_Di),
    .RAM_NBR_Do(RAM_NBR_Do), .RAM_NBR_EN(RAM_NBR_EN), .RAM_NBR_WE(RAM_NBR_WE),
    .RAM_NBR_A(RAM_NBR_A), .RAM_NBR_Di(RAM_NBR_Di),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Synchronous RAMs sampling on the rising edge, read-before-write.
  logic [31:0] obj_mem [0:DEPTH-1];
  logic [31:0] nbr_mem [0:DEPTH-1];
  always @(posedge clk) if (RAM_OBJ_EN) RAM_OBJ_Do <= obj_mem[RAM_OBJ_A];
  always @(posedge clk) begin
    if (RAM_NBR_EN) begin
      for (int i = 0; i < 4; i++)
        if (RAM_NBR_WE[i]) nbr_mem[RAM_NBR_A][8*i +: 8] <= RAM_NBR_Di[8*i +: 8];
      RAM_NBR_Do <= nbr_mem[RAM_NBR_A];
    end
  end

  int done_cnt = 0;
  bit obj_wr_seen = 1'b0;
  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (RAM_OBJ_WE != 4'd0 || RAM_OBJ_Di != 32'd0) obj_wr_seen <= 1'b1;
  end

  // Mesh under test and reference model.
  int m_vc, m_fc;
  int m_face [0:63][0:2];
  int exp_list [1:64][$];
  bit exp_ovf;

  function automatic void build_model();
    int pairs [6][2] = '{'{0,1}, '{1,0}, '{1,2}, '{2,1}, '{2,0}, '{0,2}};
    int s, d;
    bit seen;
    exp_ovf = 1'b0;
    for (int v = 1; v <= 64; v++) exp_list[v].delete();
    for (int f = 0; f < m_fc; f++) begin
      for (int e = 0; e < 6; e++) begin
        s = m_face[f][pairs[e][0]];
        d = m_face[f][pairs[e][1]];
        seen = 1'b0;
`ifdef NBR_DEDUP_EN
        foreach (exp_list[s][j]) if (exp_list[s][j] == d) seen = 1'b1;
`endif
        if (!seen) begin
          if (exp_list[s].size() < MAXN - 1) exp_list[s].push_back(d);
          else exp_ovf = 1'b1;
        end
      end
    end
  endfunction

  // Number of slot words differing from the model; reports the first one.
  function automatic int count_bad_words(output int bad_addr, output logic [31:0] bad_got,
                                         output int bad_exp);
    int bad, base, e;
    bad = 0; bad_addr = -1; bad_got = '0; bad_exp = 0;
    for (int v = 1; v <= m_vc; v++) begin
      base = (v - 1) * MAXN;
      for (int j = 0; j <= exp_list[v].size(); j++) begin
        if (j == 0) e = exp_list[v].size();
        else e = exp_list[v][j-1];
        if (nbr_mem[base+j] !== 32'(e)) begin
          if (bad == 0) begin bad_addr = base + j; bad_got = nbr_mem[base+j]; bad_exp = e; end
          bad++;
        end
      end
    end
    return bad;
  endfunction

  task automatic load_mesh();
    obj_mem[0] = 32'(m_vc);
    for (int v = 1; v <= m_vc; v++)
      for (int k = 0; k < 3; k++) obj_mem[3*v-2+k] = $urandom;
    for (int f = 0; f < m_fc; f++)
      for (int k = 0; k < 3; k++) obj_mem[m_vc*3+1+3*f+k] = 32'(m_face[f][k]);
    build_model();
  endtask

  task automatic set_tri();
    m_vc = 3; m_fc = 1; m_face[0] = '{1, 2, 3};
  endtask

  task automatic set_two_faces();
    m_vc = 4; m_fc = 2; m_face[0] = '{1, 2, 3}; m_face[1] = '{1, 3, 4};
  endtask

  // Pulse start, wait (bounded) for completion, count done pulses.
  task automatic run_build(input bit poke_busy, output bit fin, output int dones,
                           output logic busy0, output logic ovf0);
    int d0;
    fin = 1'b0;
    vertex_count = 32'(m_vc);
    face_count   = 32'(m_fc);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    busy0 = busy; ovf0 = overflow; d0 = done_cnt;
    for (int i = 0; i < 20000 && !fin; i++) begin
      @(posedge clk); #1;
      start = poke_busy && (i == 2 || i == 7);
      if (done_cnt != d0 && !busy) fin = 1'b1;
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 dones = done_cnt - d0;
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    n_checks++; if ({busy, done, overflow, RAM_OBJ_EN, RAM_NBR_EN} !== 5'd0) begin n_err++;
      $display("FAIL reset_flags: got %b expected 00000", {busy, done, overflow, RAM_OBJ_EN, RAM_NBR_EN}); end
    n_checks++; if ({RAM_OBJ_WE, RAM_NBR_WE} !== 8'd0) begin n_err++;
      $display("FAIL reset_we: got %h expected 00", {RAM_OBJ_WE, RAM_NBR_WE}); end
    n_checks++; if ({RAM_OBJ_A, RAM_NBR_A, RAM_OBJ_Di, RAM_NBR_Di} !== '0) begin n_err++;
      $display("FAIL reset_addr_data: got %h/%h/%h/%h expected 0", RAM_OBJ_A, RAM_NBR_A, RAM_OBJ_Di, RAM_NBR_Di); end
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_checks++; if ({busy, done} !== 2'b00) begin n_err++;
      $display("FAIL idle_after_reset: busy/done got %b expected 00", {busy, done}); end
  endtask

  task automatic test_basic_triangle();
    bit fin; int dn, bad, ba, be; logic b0, o0; logic [31:0] bg;
    set_tri(); load_mesh();
    run_build(1'b0, fin, dn, b0, o0);
    n_checks++; if (!fin) begin n_err++; $display("FAIL tri_timeout: got no done expected done"); end
    n_checks++; if (b0 !== 1'b1) begin n_err++; $display("FAIL tri_busy: got %b expected 1", b0); end
    n_checks++; if (dn !== 1) begin n_err++; $display("FAIL tri_done_pulses: got %0d expected 1", dn); end
    n_checks++; if (overflow !== 1'b0) begin n_err++; $display("FAIL tri_overflow: got %b expected 0", overflow); end
    bad = count_bad_words(ba, bg, be);
    n_checks++; if (bad !== 0) begin n_err++;
      $display("FAIL tri_slots: %0d bad words, addr %0d got %0d expected %0d", bad, ba, bg, be); end
    n_checks++; if ({nbr_mem[0], nbr_mem[1], nbr_mem[2]} !== {32'd2, 32'd2, 32'd3}) begin n_err++;
      $display("FAIL tri_slot1: got {%0d,%0d,%0d} expected {2,2,3}", nbr_mem[0], nbr_mem[1], nbr_mem[2]); end
    n_checks++; if ({nbr_mem[20], nbr_mem[21], nbr_mem[22]} !== {32'd2, 32'd2, 32'd1}) begin n_err++;
      $display("FAIL tri_slot3: got {%0d,%0d,%0d} expected {2,2,1}", nbr_mem[20], nbr_mem[21], nbr_mem[22]); end
  endtask

  task automatic test_two_faces();
    bit fin; int dn, bad, ba, be; logic b0, o0; logic [31:0] bg;
    logic [31:0] lit_cnt;
    set_two_faces(); load_mesh();
    run_build(1'b0, fin, dn, b0, o0);
`ifdef NBR_DEDUP_EN
    lit_cnt = 32'd3;
`else
    lit_cnt = 32'd4;
`endif
    n_checks++; if (!fin || dn !== 1) begin n_err++;
      $display("FAIL two_faces_done: got fin=%0d pulses=%0d expected fin=1 pulses=1", fin, dn); end
    bad = count_bad_words(ba, bg, be);
    n_checks++; if (bad !== 0) begin n_err++;
      $display("FAIL two_faces_slots: %0d bad words, addr %0d got %0d expected %0d", bad, ba, bg, be); end
    n_checks++; if (nbr_mem[0] !== lit_cnt) begin n_err++;
      $display("FAIL two_faces_slot1_count: got %0d expected %0d", nbr_mem[0], lit_cnt); end
  endtask

  task automatic test_overflow();
    bit fin; int dn, bad, ba, be; logic b0, o0; logic [31:0] bg;
    m_vc = 12; m_fc = 10;
    for (int k = 2; k <= 11; k++) m_face[k-2] = '{1, k, k + 1};
    load_mesh();
    run_build(1'b0, fin, dn, b0, o0);
    n_checks++; if (!fin || dn !== 1) begin n_err++;
      $display("FAIL ovf_done: got fin=%0d pulses=%0d expected fin=1 pulses=1", fin, dn); end
    n_checks++; if (overflow !== exp_ovf) begin n_err++;
      $display("FAIL ovf_flag: got %b expected %b", overflow, exp_ovf); end
    n_checks++; if (nbr_mem[0] !== 32'd9) begin n_err++;
      $display("FAIL ovf_slot1_count: got %0d expected 9", nbr_mem[0]); end
    bad = count_bad_words(ba, bg, be);
    n_checks++; if (bad !== 0) begin n_err++;
      $display("FAIL ovf_slots: %0d bad words, addr %0d got %0d expected %0d", bad, ba, bg, be); end
    repeat (10) @(posedge clk); #1;
    n_checks++; if (overflow !== 1'b1) begin n_err++;
      $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    set_tri(); load_mesh();
    run_build(1'b0, fin, dn, b0, o0);
    n_checks++; if (o0 !== 1'b0) begin n_err++;
      $display("FAIL ovf_clear_on_start: got %b expected 0", o0); end
    n_checks++; if (overflow !== 1'b0) begin n_err++;
      $display("FAIL ovf_after_clean_build: got %b expected 0", overflow); end
  endtask

  task automatic test_random();
    bit fin; int dn, bad, ba, be; logic b0, o0; logic [31:0] bg;
    for (int t = 0; t < 6; t++) begin
      m_vc = $urandom_range(3, 20);
      m_fc = $urandom_range(1, 12);
      for (int f = 0; f < m_fc; f++)
        for (int k = 0; k < 3; k++) m_face[f][k] = $urandom_range(1, m_vc);
      load_mesh();
      run_build(1'b0, fin, dn, b0, o0);
      n_checks++; if (!fin || dn !== 1) begin n_err++;
        $display("FAIL rand%0d_done: got fin=%0d pulses=%0d expected fin=1 pulses=1", t, fin, dn); end
      n_checks++; if (overflow !== exp_ovf) begin n_err++;
        $display("FAIL rand%0d_overflow: got %b expected %b", t, overflow, exp_ovf); end
      bad = count_bad_words(ba, bg, be);
      n_checks++; if (bad !== 0) begin n_err++;
        $display("FAIL rand%0d_slots: vc=%0d fc=%0d, %0d bad words, addr %0d got %0d expected %0d",
                 t, m_vc, m_fc, bad, ba, bg, be); end
    end
    n_checks++; if (obj_wr_seen !== 1'b0) begin n_err++;
      $display("FAIL obj_ram_readonly: got write activity expected none"); end
  endtask

  task automatic test_face_zero();
    bit fin; int dn, bad, ba, be; logic b0, o0; logic [31:0] bg;
    m_vc = 5; m_fc = 0; load_mesh();
    for (int i = 0; i < 5; i++) obj_mem[0] = 32'd5;
    run_build(1'b0, fin, dn, b0, o0);
    n_checks++; if (!fin || dn !== 1) begin n_err++;
      $display("FAIL face0_done: got fin=%0d pulses=%0d expected fin=1 pulses=1", fin, dn); end
    bad = count_bad_words(ba, bg, be);
    n_checks++; if (bad !== 0) begin n_err++;
      $display("FAIL face0_cleared: %0d bad words, addr %0d got %0d expected %0d", bad, ba, bg, be); end
    m_vc = 0; m_fc = 0; load_mesh();
    run_build(1'b0, fin, dn, b0, o0);
    n_checks++; if (!fin || dn !== 1) begin n_err++;
      $display("FAIL vtx0_done: got fin=%0d pulses=%0d expected fin=1 pulses=1", fin, dn); end
  endtask

  task automatic test_reset_mid_build();
    bit fin; int dn, bad, ba, be; logic b0, o0; logic [31:0] bg; logic busy_pre;
    set_two_faces(); load_mesh();
    vertex_count = 32'(m_vc); face_count = 32'(m_fc);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (14) @(posedge clk);
    #1 busy_pre = busy;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (busy_pre !== 1'b1) begin n_err++;
      $display("FAIL midrst_was_busy: got %b expected 1", busy_pre); end
    n_checks++; if ({busy, done, overflow, RAM_OBJ_EN, RAM_NBR_EN, RAM_NBR_WE} !== 9'd0) begin n_err++;
      $display("FAIL midrst_outputs: got %b expected 0",
               {busy, done, overflow, RAM_OBJ_EN, RAM_NBR_EN, RAM_NBR_WE}); end
    n_checks++; if ({RAM_OBJ_A, RAM_NBR_A, RAM_NBR_Di} !== '0) begin n_err++;
      $display("FAIL midrst_addr_data: got %h/%h/%h expected 0", RAM_OBJ_A, RAM_NBR_A, RAM_NBR_Di); end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    set_tri(); load_mesh();
    run_build(1'b0, fin, dn, b0, o0);
    bad = count_bad_words(ba, bg, be);
    n_checks++; if (!fin || dn !== 1 || bad !== 0) begin n_err++;
      $display("FAIL midrst_rebuild: got fin=%0d pulses=%0d bad=%0d expected 1/1/0", fin, dn, bad); end
  endtask

  task automatic test_start_while_busy();
    bit fin; int dn, bad, ba, be; logic b0, o0; logic [31:0] bg;
    set_tri(); load_mesh();
    run_build(1'b1, fin, dn, b0, o0);
    n_checks++; if (!fin || dn !== 1) begin n_err++;
      $display("FAIL busy_start_done: got fin=%0d pulses=%0d expected fin=1 pulses=1", fin, dn); end
    bad = count_bad_words(ba, bg, be);
    n_checks++; if (bad !== 0) begin n_err++;
      $display("FAIL busy_start_slots: %0d bad words, addr %0d got %0d expected %0d", bad, ba, bg, be); end
    n_checks++; if (busy !== 1'b0) begin n_err++;
      $display("FAIL busy_start_idle: got busy=%b expected 0", busy); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; vertex_count = '0; face_count = '0;
    test_reset();
    test_basic_triangle();
    test_two_faces();
    test_overflow();
    test_random();
    test_face_zero();
    test_reset_mid_build();
    test_start_while_busy();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
